piso_shift_register: RTL and testbench

Parallel-in, serial-out transmitter that drains an n-bit word onto a 1-bit stream. It is the unload side of the team's n-bit load register. A parallel word is captured on a load handshake and emitted one bit per accepted transfer under valid/ready flow control. A done pulse marks the end of each word. It sits between a parallel datapath register and a serial link or bit-serial consumer.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_shift_register_if.sv | 24 ++
 rtl/piso_shift_register_bit_down_counter.sv | 32 +++
 rtl/piso_shift_register.sv | 116 +++++++++++
 tb/tb_piso_shift_register.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

  // Transmitter control states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a counter able to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_shift_register_if.sv
// Load and serial handshake bundle between the datapath, the transmitter and the serial consumer.
interface piso_shift_register_if #(
  parameter int n = 4
);
  logic         load;
  logic [n-1:0] I;
  logic         ready;
  logic         sout;
  logic         sout_valid;
  logic         sout_ready;
  logic         done;

  // Producer/consumer side: drives load, data and serial back-pressure.
  modport master (
    output load, I, sout_ready,
    input  ready, sout, sout_valid, done
  );

  // Transmitter side.
  modport slave (
    input  load, I, sout_ready,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_shift_register_bit_down_counter.sv
// Loadable down-counter tracking the bits still to be sent; flags one and zero remaining.
module bit_down_counter #(
  parameter int W        = 3,
  parameter int LOAD_VAL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last,
  output logic zero
);

  logic [W-1:0] cnt_r;

  // Count register: a load wins over a decrement; never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= W'(LOAD_VAL);
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == W'(1));
  assign zero = (cnt_r == '0);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter: captures a word on load, emits it one bit per
// accepted transfer, pulses done after the last bit, and allows gap-free back-to-back words.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int n         = 4,
  parameter int MSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  piso_shift_register_if.slave bus
);

  localparam int CW = cnt_width(n);

  state_t       state_r;
  state_t       next_state_s;
  logic [n-1:0] sr_r;
  logic [n-1:0] shifted_s;
  logic         done_r;
  logic         last_s;
  logic         zero_s;
  logic         ready_s;
  logic         accept_s;
  logic         xfer_s;
  logic         valid_s;

  assign valid_s  = (state_r == SHIFT);
  assign xfer_s   = valid_s && bus.sout_ready;
  // The final bit leaving this cycle frees the register for the next word.
  assign ready_s  = (state_r == IDLE) || (valid_s && last_s && bus.sout_ready);
  assign accept_s = bus.load && ready_s;

  bit_down_counter #(
    .W        (CW),
    .LOAD_VAL (n)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept_s),
    .dec   (xfer_s),
    .last  (last_s),
    .zero  (zero_s)
  );

  // Next-state logic; a SHIFT with nothing left to send falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s) begin
          next_state_s = SHIFT;
        end else if ((xfer_s && last_s) || zero_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SHIFT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // One-bit move toward the output end, zero filled.
  always_comb begin
    shifted_s = sr_r;
    if (MSB_FIRST != 0) begin
      shifted_s = sr_r << 1'b1;
    end else begin
      shifted_s = sr_r >> 1'b1;
    end
  end

  // Shift register: capture on accepted load, advance on transfer, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r <= '0;
    end else if (accept_s) begin
      sr_r <= bus.I;
    end else if (xfer_s) begin
      sr_r <= shifted_s;
    end else begin
      sr_r <= sr_r;
    end
  end

  // Done pulse in the cycle after the last bit is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= xfer_s && last_s;
    end
  end

  assign bus.ready      = ready_s;
  assign bus.sout_valid = valid_s;
  assign bus.sout       = (MSB_FIRST != 0) ? sr_r[n-1] : sr_r[0];
  assign bus.done       = done_r;

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench: three transmitters (4-bit MSB-first, 4-bit LSB-first, 1-bit) share one
// stimulus stream and are compared every cycle against a word/remaining-count reference model.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] din;
  logic       sready;

  always #5 clk = ~clk;

  piso_shift_register_if #(.n(4)) if_m ();
  piso_shift_register_if #(.n(4)) if_l ();
  piso_shift_register_if #(.n(1)) if_1 ();

  assign if_m.load = load;  assign if_m.I = din;     assign if_m.sout_ready = sready;
  assign if_l.load = load;  assign if_l.I = din;     assign if_l.sout_ready = sready;
  assign if_1.load = load;  assign if_1.I = din[0];  assign if_1.sout_ready = sready;

  piso_shift_register #(.n(4), .MSB_FIRST(1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m));
  piso_shift_register #(.n(4), .MSB_FIRST(0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l));
  piso_shift_register #(.n(1), .MSB_FIRST(1)) dut_1 (.clk(clk), .rst_n(rst_n), .bus(if_1));

  // Observed outputs packed as {ready, sout_valid, sout, done}.
  logic [3:0] act [3];
  assign act[0] = {if_m.ready, if_m.sout_valid, if_m.sout, if_m.done};
  assign act[1] = {if_l.ready, if_l.sout_valid, if_l.sout, if_l.done};
  assign act[2] = {if_1.ready, if_1.sout_valid, if_1.sout, if_1.done};

  int errors = 0;
  int checks = 0;

  // Reference model: held word, bits remaining, pending done.
  int mn   [3] = '{4, 4, 1};
  int mmsb [3] = '{1, 0, 1};
  int mword[3];
  int mrem [3];
  bit mdone[3];

  // Bookkeeping for the hand-written sequences (dut_m only).
  logic [31:0] stream_m;
  int          stream_len;
  int          done_cnt;
  int          valid_cnt;
  int          cyc;
  int          last_done_cyc;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  function automatic logic [3:0] model_exp(input int k, input bit sr);
    bit v, b, r;
    v = (mrem[k] > 0);
    b = 1'b0;
    if (v) begin
      if (mmsb[k] != 0) b = ((mword[k] >> (mrem[k] - 1)) & 1) != 0;
      else              b = ((mword[k] >> (mn[k] - mrem[k])) & 1) != 0;
    end
    r = (mrem[k] == 0) || (mrem[k] == 1 && sr);
    return {r, v, b, mdone[k]};
  endfunction

  task automatic model_edge(input int k, input bit ld, input logic [3:0] d, input bit sr);
    bit xfer, rdy;
    xfer     = (mrem[k] > 0) && sr;
    rdy      = (mrem[k] == 0) || (mrem[k] == 1 && sr);
    mdone[k] = xfer && (mrem[k] == 1);
    if (xfer) mrem[k]--;
    if (ld && rdy) begin
      mword[k] = int'(d) & ((1 << mn[k]) - 1);
      mrem[k]  = mn[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mword[k] = 0; mrem[k] = 0; mdone[k] = 1'b0;
    end
  endtask

  // Drive inputs for this cycle, then compare all DUTs with the model and log dut_m activity.
  task automatic apply(input bit ld, input logic [3:0] d, input bit sr);
    load = ld; din = d; sready = sr;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("model_dut%0d", k), {28'd0, act[k]}, {28'd0, model_exp(k, sr)});
    if (if_m.sout_valid) valid_cnt++;
    if (if_m.sout_valid && sr) begin
      stream_m = {stream_m[30:0], if_m.sout};
      stream_len++;
    end
    if (if_m.done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_edge(k, load, din, sready);
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle(input bit ld, input logic [3:0] d, input bit sr);
    apply(ld, d, sr);
    advance();
  endtask

  task automatic clear_log();
    stream_m = 32'd0; stream_len = 0; done_cnt = 0; valid_cnt = 0; cyc = 0; last_done_cyc = -1;
  endtask

  // Asynchronous reset asserted mid low phase; outputs must fall to idle values at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) chk($sformatf("reset_dut%0d", k), {28'd0, act[k]}, 32'h8);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         ld;
    logic [3:0] d;
    bit         sr;
    logic [3:0] exp_m;
    logic [3:0] exp_l;
  } vec_t;

  vec_t vecs [7];

  initial begin
    rst_n = 1'b0; load = 1'b0; din = 4'h0; sready = 1'b1;
    model_reset();
    clear_log();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // Basic word 4'b1011: MSB-first 1,0,1,1 and LSB-first 1,1,0,1; done in T+5.
    vecs[0] = '{1'b1, 4'hB, 1'b1, 4'b1000, 4'b1000};
    vecs[1] = '{1'b0, 4'h0, 1'b1, 4'b0110, 4'b0110};
    vecs[2] = '{1'b0, 4'h0, 1'b1, 4'b0100, 4'b0110};
    vecs[3] = '{1'b0, 4'h0, 1'b1, 4'b0110, 4'b0100};
    vecs[4] = '{1'b0, 4'h0, 1'b1, 4'b1110, 4'b1110};
    vecs[5] = '{1'b0, 4'h0, 1'b1, 4'b1001, 4'b1001};
    vecs[6] = '{1'b0, 4'h0, 1'b1, 4'b1000, 4'b1000};
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].ld, vecs[i].d, vecs[i].sr);
      chk($sformatf("vec%0d_msb", i), {28'd0, act[0]}, {28'd0, vecs[i].exp_m});
      chk($sformatf("vec%0d_lsb", i), {28'd0, act[1]}, {28'd0, vecs[i].exp_l});
      advance();
    end

    // Stall: 4'b1100 with two stall cycles after the first bit; done two cycles late.
    clear_log();
    begin
      bit sr_pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int k = 0; k < 10; k++) begin
        apply(k == 0, 4'hC, sr_pat[k]);
        if (k == 2 || k == 3) chk("stall_hold", {30'd0, if_m.sout_valid, if_m.sout}, 32'd3);
        advance();
      end
    end
    chk("stall_stream", stream_m, 32'hC);
    chk("stall_len", stream_len, 32'd4);
    chk("stall_done_cycle", last_done_cyc, 32'd7);
    chk("stall_done_count", done_cnt, 32'd1);

    // Back-to-back with load held: 4'h5 captured only on the last-bit edge of 4'hA.
    clear_log();
    cycle(1'b1, 4'hA, 1'b1);
    for (int k = 1; k <= 4; k++) cycle(1'b1, 4'h5, 1'b1);
    for (int k = 5; k <= 7; k++) cycle(1'b0, 4'hF, 1'b1);
    for (int k = 8; k <= 10; k++) cycle(1'b0, 4'h0, 1'b1);
    chk("b2b_stream", stream_m, 32'hA5);
    chk("b2b_len", stream_len, 32'd8);
    chk("b2b_valid_cycles", valid_cnt, 32'd8);
    chk("b2b_done_count", done_cnt, 32'd2);

    // Reset mid-word: 4'hF dropped without done; a fresh 4'h3 then sends 0,0,1,1.
    clear_log();
    cycle(1'b1, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    do_reset();
    clear_log();
    cycle(1'b0, 4'h0, 1'b1);
    chk("rst_no_done", done_cnt, 32'd0);
    cycle(1'b1, 4'h3, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 1'b1);
    chk("rst_stream", stream_m, 32'h3);
    chk("rst_len", stream_len, 32'd4);
    chk("rst_done_count", done_cnt, 32'd1);

    // Randomized traffic with back-pressure, busy loads and rare resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
